// File: rtl/hpdcache_victim_alloc_if.sv
// Port bundle of the victim allocation sequencer.
// slave is the sequencer's view, master is its environment's view.
interface hpdcache_victim_alloc_if #(
    parameter int unsigned Sets     = 64,
    parameter int unsigned Ways     = 8,
    parameter int unsigned TagWidth = 20
);
    localparam int unsigned SetW = $clog2(Sets);

    // refill allocation request from the miss handler
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [SetW-1:0]          req_set_i;
    logic [TagWidth-1:0]      req_tag_i;

    // directory read port, data returned one cycle after the strobe
    logic                     dir_rd_o;
    logic [SetW-1:0]          dir_rd_set_o;
    logic [Ways-1:0]          dir_valid_i;
    logic [Ways-1:0]          dir_dirty_i;
    logic [Ways-1:0]          dir_fetch_i;
    logic [Ways*TagWidth-1:0] dir_tag_i;

    // replacement-policy victim selection
    logic                     sel_victim_o;
    logic [SetW-1:0]          sel_victim_set_o;
    logic [Ways-1:0]          sel_dir_valid_o;
    logic [Ways-1:0]          sel_dir_dirty_o;
    logic [Ways-1:0]          sel_dir_fetch_o;
    logic [Ways-1:0]          sel_victim_way_i;

    // replacement-policy touch
    logic                     updt_o;
    logic [SetW-1:0]          updt_set_o;
    logic [Ways-1:0]          updt_way_o;

    // writeback of a dirty victim
    logic                     wb_valid_o;
    logic                     wb_ready_i;
    logic [SetW-1:0]          wb_set_o;
    logic [Ways-1:0]          wb_way_o;
    logic [TagWidth-1:0]      wb_tag_o;

    // directory update marking the chosen way as fetching
    logic                     alloc_o;
    logic [SetW-1:0]          alloc_set_o;
    logic [Ways-1:0]          alloc_way_o;
    logic [TagWidth-1:0]      alloc_tag_o;

    // allocation result back to the miss handler
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [Ways-1:0]          rsp_way_o;
    logic                     rsp_wback_o;
    logic                     rsp_fail_o;

    modport slave (
        input  req_valid_i, req_set_i, req_tag_i,
        output req_ready_o,
        output dir_rd_o, dir_rd_set_o,
        input  dir_valid_i, dir_dirty_i, dir_fetch_i, dir_tag_i,
        output sel_victim_o, sel_victim_set_o,
        output sel_dir_valid_o, sel_dir_dirty_o, sel_dir_fetch_o,
        input  sel_victim_way_i,
        output updt_o, updt_set_o, updt_way_o,
        output wb_valid_o, wb_set_o, wb_way_o, wb_tag_o,
        input  wb_ready_i,
        output alloc_o, alloc_set_o, alloc_way_o, alloc_tag_o,
        output rsp_valid_o, rsp_way_o, rsp_wback_o, rsp_fail_o,
        input  rsp_ready_i
    );

    modport master (
        output req_valid_i, req_set_i, req_tag_i,
        input  req_ready_o,
        input  dir_rd_o, dir_rd_set_o,
        output dir_valid_i, dir_dirty_i, dir_fetch_i, dir_tag_i,
        input  sel_victim_o, sel_victim_set_o,
        input  sel_dir_valid_o, sel_dir_dirty_o, sel_dir_fetch_o,
        output sel_victim_way_i,
        input  updt_o, updt_set_o, updt_way_o,
        input  wb_valid_o, wb_set_o, wb_way_o, wb_tag_o,
        output wb_ready_i,
        input  alloc_o, alloc_set_o, alloc_way_o, alloc_tag_o,
        input  rsp_valid_o, rsp_way_o, rsp_wback_o, rsp_fail_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/hpdcache_victim_alloc.sv
// Miss-allocation sequencer: directory read, victim selection,
// optional dirty writeback, directory allocation and PLRU touch.
module hpdcache_victim_alloc #(
    parameter int unsigned Sets     = 64,
    parameter int unsigned Ways     = 8,
    parameter int unsigned TagWidth = 20,
    parameter int unsigned MaxRetry = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    hpdcache_victim_alloc_if.slave bus
);
    localparam int unsigned SetW = $clog2(Sets);
    localparam int unsigned CntW = $clog2(MaxRetry + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxRetry);

    typedef enum logic [2:0] {
        IDLE,
        DIR_RD,
        SELECT,
        WB,
        ALLOC,
        RSP
    } state_e;

    state_e              state_q, state_d;
    logic [SetW-1:0]     set_q, set_d;
    logic [TagWidth-1:0] tag_q, tag_d;
    logic [Ways-1:0]     way_q, way_d;
    logic [TagWidth-1:0] vtag_q, vtag_d;
    logic                wback_q, wback_d;
    logic                fail_q, fail_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic                vic_valid;
    logic                vic_dirty;
    logic [TagWidth-1:0] vic_tag;
    logic [CntW-1:0]     cnt_inc;

    // state of the victim picked by the policy, muxed by its one-hot way
    always_comb begin
        vic_tag = '0;
        for (int w = 0; w < int'(Ways); w++) begin
            if (bus.sel_victim_way_i[w]) begin
                vic_tag = vic_tag | bus.dir_tag_i[w*TagWidth +: TagWidth];
            end
        end
        vic_valid = |(bus.sel_victim_way_i & bus.dir_valid_i);
        vic_dirty = |(bus.sel_victim_way_i & bus.dir_dirty_i);
        cnt_inc   = (cnt_q >= MaxCnt) ? MaxCnt : cnt_q + 1'b1;
    end

    // sequencer next state and registered result fields
    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        tag_d   = tag_q;
        way_d   = way_q;
        vtag_d  = vtag_q;
        wback_d = wback_q;
        fail_d  = fail_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    set_d   = bus.req_set_i;
                    tag_d   = bus.req_tag_i;
                    way_d   = '0;
                    wback_d = 1'b0;
                    fail_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = DIR_RD;
                end
            end
            DIR_RD: begin
                state_d = SELECT;
            end
            SELECT: begin
                way_d  = bus.sel_victim_way_i;
                vtag_d = vic_tag;
                if (bus.sel_victim_way_i == '0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= MaxCnt) begin
                        fail_d  = 1'b1;
                        state_d = RSP;
                    end else begin
                        state_d = DIR_RD;
                    end
                end else if (vic_valid && vic_dirty) begin
                    state_d = WB;
                end else begin
                    state_d = ALLOC;
                end
            end
            WB: begin
                if (bus.wb_ready_i) begin
                    wback_d = 1'b1;
                    state_d = ALLOC;
                end
            end
            ALLOC: begin
                state_d = RSP;
            end
            RSP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state registers, cleared by synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            set_q   <= '0;
            tag_q   <= '0;
            way_q   <= '0;
            vtag_q  <= '0;
            wback_q <= 1'b0;
            fail_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            tag_q   <= tag_d;
            way_q   <= way_d;
            vtag_q  <= vtag_d;
            wback_q <= wback_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
        end
    end

    // strobes decode registered state only
    assign bus.req_ready_o  = (state_q == IDLE);
    assign bus.dir_rd_o     = (state_q == DIR_RD);
    assign bus.sel_victim_o = (state_q == SELECT);
    assign bus.wb_valid_o   = (state_q == WB);
    assign bus.alloc_o      = (state_q == ALLOC);
    assign bus.updt_o       = (state_q == ALLOC);
    assign bus.rsp_valid_o  = (state_q == RSP);

    assign bus.dir_rd_set_o     = set_q;
    assign bus.sel_victim_set_o = set_q;
    assign bus.sel_dir_valid_o  = bus.dir_valid_i;
    assign bus.sel_dir_dirty_o  = bus.dir_dirty_i;
    assign bus.sel_dir_fetch_o  = bus.dir_fetch_i;

    assign bus.wb_set_o = set_q;
    assign bus.wb_way_o = way_q;
    assign bus.wb_tag_o = vtag_q;

    assign bus.alloc_set_o = set_q;
    assign bus.alloc_way_o = way_q;
    assign bus.alloc_tag_o = tag_q;
    assign bus.updt_set_o  = set_q;
    assign bus.updt_way_o  = way_q;

    assign bus.rsp_way_o   = way_q;
    assign bus.rsp_wback_o = wback_q;
    assign bus.rsp_fail_o  = fail_q;
endmodule

// File: tb/tb_hpdcache_victim_alloc.sv
// Randomized bench for hpdcache_victim_alloc with a transaction-level
// model of retry, victim choice, writeback and response timing.
module tb_hpdcache_victim_alloc;
    localparam int SETS = 64;
    localparam int WAYS = 8;
    localparam int TW   = 20;
    localparam int MR   = 4;
    localparam int SW   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hpdcache_victim_alloc_if #(
        .Sets(SETS), .Ways(WAYS), .TagWidth(TW)
    ) bus ();

    hpdcache_victim_alloc #(
        .Sets(SETS), .Ways(WAYS), .TagWidth(TW), .MaxRetry(MR)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pol_start = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // policy: non-fetching invalid way first, then any non-fetching
    // way, scanning from a rotating start; none -> 0
    function automatic logic [WAYS-1:0] pick(input logic [WAYS-1:0] v,
                                             input logic [WAYS-1:0] f,
                                             input int start);
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < WAYS; k++) begin
                int w;
                w = (start + k) % WAYS;
                if (!f[w] && (pass == 1 || !v[w]))
                    return WAYS'(1) << w;
            end
        end
        return '0;
    endfunction

    // replacement-policy stand-in
    always_comb begin
        bus.sel_victim_way_i = '0;
        if (bus.sel_victim_o)
            bus.sel_victim_way_i = pick(bus.sel_dir_valid_o,
                                        bus.sel_dir_fetch_o, pol_start);
    end

    task automatic run_txn(
        input logic [SW-1:0] set, input logic [TW-1:0] tag,
        input logic [WAYS-1:0] dv, input logic [WAYS-1:0] dd,
        input logic [WAYS-1:0] df, input logic [WAYS*TW-1:0] tags,
        input int block, input int wb_stall, input int rsp_stall,
        input bit hold_valid, input bit abort_wb);
        int a, e_rsp, wait_c;
        logic [WAYS-1:0] ew, f;
        bit efail, edirty, done, prev_rd;
        logic [TW-1:0] etag;
        int n_rd, n_sel, n_wb, n_wbv, n_alloc, n_updt, n_rspv;
        int alloc_c, updt_c, rsp_c, bad_ready, bad_set, wb_bad, rsp_bad;
        logic [SW-1:0] wb_s, al_s, up_s;
        logic [WAYS-1:0] wb_w, al_w, up_w, rs_w;
        logic [TW-1:0] wb_t, al_t;
        logic rs_wb, rs_f;

        // expected outcome straight from the allocation rules
        a = 0;
        ew = '0;
        while (ew == '0 && a < MR) begin
            a++;
            f = (a <= block) ? '1 : df;
            ew = pick(dv, f, pol_start);
        end
        efail = (ew == '0);
        edirty = |(ew & dv & dd);
        etag = '0;
        for (int w = 0; w < WAYS; w++)
            if (ew[w]) etag = tags[w*TW +: TW];
        if (efail) e_rsp = 2 * a + 1;
        else if (edirty) e_rsp = 2 * a + 3 + wb_stall;
        else e_rsp = 2 * a + 2;

        n_rd = 0; n_sel = 0; n_wb = 0; n_wbv = 0; n_alloc = 0;
        n_updt = 0; n_rspv = 0; alloc_c = -1; updt_c = -1; rsp_c = -1;
        bad_ready = 0; bad_set = 0; wb_bad = 0; rsp_bad = 0;
        wb_s = '0; wb_w = '0; wb_t = '0; al_s = '0; al_w = '0; al_t = '0;
        up_s = '0; up_w = '0; rs_w = '0; rs_wb = 1'b0; rs_f = 1'b0;
        done = 1'b0; prev_rd = 1'b0;

        bus.req_valid_i = 1'b1;
        bus.req_set_i = set;
        bus.req_tag_i = tag;
        wait_c = 0;
        while (!bus.req_ready_o && wait_c < 20) begin
            @(posedge clk); #2;
            wait_c++;
        end
        chk("accept_wait", 64'(wait_c), 64'd0);
        @(posedge clk);

        for (int c = 1; c <= 60 && !done; c++) begin
            if (c > 1) @(posedge clk);
            #1;
            bus.req_valid_i = hold_valid;
            if (prev_rd) begin
                bus.dir_valid_i = dv;
                bus.dir_dirty_i = dd;
                bus.dir_fetch_i = (n_rd <= block) ? '1 : df;
                bus.dir_tag_i = tags;
            end else begin
                bus.dir_valid_i = WAYS'($urandom);
                bus.dir_dirty_i = WAYS'($urandom);
                bus.dir_fetch_i = WAYS'($urandom);
                bus.dir_tag_i = {5{$urandom}};
            end
            bus.wb_ready_i = (n_wbv >= wb_stall);
            bus.rsp_ready_i = (n_rspv >= rsp_stall);
            #1;
            if (bus.req_ready_o) bad_ready++;
            prev_rd = bus.dir_rd_o;
            if (bus.dir_rd_o) begin
                n_rd++;
                if (bus.dir_rd_set_o !== set) bad_set++;
            end
            if (bus.sel_victim_o) begin
                n_sel++;
                if (bus.sel_victim_set_o !== set) bad_set++;
            end
            if (bus.wb_valid_o) begin
                if (n_wbv == 0) begin
                    wb_s = bus.wb_set_o; wb_w = bus.wb_way_o;
                    wb_t = bus.wb_tag_o;
                end else if (bus.wb_set_o !== wb_s || bus.wb_way_o !== wb_w
                             || bus.wb_tag_o !== wb_t) begin
                    wb_bad++;
                end
                n_wbv++;
                if (bus.wb_ready_i) n_wb++;
            end else if (n_wbv > 0 && n_wb == 0) begin
                wb_bad++;
            end
            if (bus.alloc_o) begin
                n_alloc++; alloc_c = c;
                al_s = bus.alloc_set_o; al_w = bus.alloc_way_o;
                al_t = bus.alloc_tag_o;
            end
            if (bus.updt_o) begin
                n_updt++; updt_c = c;
                up_s = bus.updt_set_o; up_w = bus.updt_way_o;
            end
            if (bus.rsp_valid_o) begin
                if (n_rspv == 0) begin
                    rsp_c = c; rs_w = bus.rsp_way_o;
                    rs_wb = bus.rsp_wback_o; rs_f = bus.rsp_fail_o;
                end else if (bus.rsp_way_o !== rs_w
                             || bus.rsp_wback_o !== rs_wb
                             || bus.rsp_fail_o !== rs_f) begin
                    rsp_bad++;
                end
                n_rspv++;
                if (bus.rsp_ready_i) done = 1'b1;
            end
            if (abort_wb && n_wbv == 2) begin
                chk("abort_wb_seen", 64'(n_wb), 64'd0);
                chk("abort_wb_tag", 64'(wb_t), 64'(etag));
                bus.req_valid_i = 1'b0;
                return;
            end
        end

        chk("rsp_done", 64'(done), 64'd1);
        chk("dir_rd_pulses", 64'(n_rd), 64'(a));
        chk("sel_pulses", 64'(n_sel), 64'(a));
        chk("set_fwd", 64'(bad_set), 64'd0);
        chk("ready_busy", 64'(bad_ready), 64'd0);
        chk("wb_count", 64'(n_wb), 64'(edirty));
        chk("wb_stable", 64'(wb_bad), 64'd0);
        if (edirty) begin
            chk("wb_set", 64'(wb_s), 64'(set));
            chk("wb_way", 64'(wb_w), 64'(ew));
            chk("wb_tag", 64'(wb_t), 64'(etag));
            chk("wb_valid_cycles", 64'(n_wbv), 64'(wb_stall + 1));
        end
        chk("alloc_count", 64'(n_alloc), 64'(!efail));
        chk("updt_count", 64'(n_updt), 64'(!efail));
        if (!efail) begin
            chk("alloc_set", 64'(al_s), 64'(set));
            chk("alloc_way", 64'(al_w), 64'(ew));
            chk("alloc_tag", 64'(al_t), 64'(tag));
            chk("updt_set", 64'(up_s), 64'(set));
            chk("updt_way", 64'(up_w), 64'(ew));
            chk("alloc_cycle", 64'(alloc_c), 64'(e_rsp - 1));
            chk("updt_cycle", 64'(updt_c), 64'(e_rsp - 1));
        end
        chk("rsp_cycle", 64'(rsp_c), 64'(e_rsp));
        chk("rsp_way", 64'(rs_w), 64'(ew));
        chk("rsp_wback", 64'(rs_wb), 64'(edirty));
        chk("rsp_fail", 64'(rs_f), 64'(efail));
        chk("rsp_stable", 64'(rsp_bad), 64'd0);
        chk("rsp_valid_cycles", 64'(n_rspv), 64'(rsp_stall + 1));

        @(posedge clk); #2;
        chk("ready_after_rsp", 64'(bus.req_ready_o), 64'd1);
        chk("rsp_dropped", 64'(bus.rsp_valid_o), 64'd0);
        bus.req_valid_i = 1'b0;
    endtask

    function automatic logic [WAYS*TW-1:0] rand_tags();
        logic [WAYS*TW-1:0] t;
        for (int w = 0; w < WAYS; w++) t[w*TW +: TW] = TW'($urandom);
        return t;
    endfunction

    initial begin
        logic [WAYS*TW-1:0] tags;
        int alloc_seen;
        logic [WAYS-1:0] df;
        int block;

        bus.req_valid_i = 1'b0;
        bus.req_set_i = '0;
        bus.req_tag_i = '0;
        bus.dir_valid_i = '0;
        bus.dir_dirty_i = '0;
        bus.dir_fetch_i = '0;
        bus.dir_tag_i = '0;
        bus.wb_ready_i = 1'b0;
        bus.rsp_ready_i = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("rst_dir_rd", 64'(bus.dir_rd_o), 64'd0);
        chk("rst_sel", 64'(bus.sel_victim_o), 64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("rst_alloc", 64'(bus.alloc_o), 64'd0);
        chk("rst_updt", 64'(bus.updt_o), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_rsp_way", 64'(bus.rsp_way_o), 64'd0);

        // empty set: clean victim on the first attempt
        pol_start = 0;
        run_txn(6'd5, 20'h12345, 8'h00, 8'h00, 8'h00, rand_tags(),
                0, 0, 0, 1'b0, 1'b0);

        // dirty victim with a stalled writeback
        pol_start = 2;
        tags = rand_tags();
        tags[2*TW +: TW] = 20'hABCDE;
        run_txn(6'd3, 20'h0F0F0, 8'hFF, 8'h04, 8'h00, tags,
                0, 3, 0, 1'b0, 1'b0);

        // every way fetching: retries exhausted
        pol_start = 1;
        run_txn(6'd9, 20'h55555, 8'hFF, 8'h00, 8'hFF, rand_tags(),
                0, 0, 0, 1'b0, 1'b0);

        // fetch clears on the third attempt
        pol_start = 4;
        run_txn(6'd17, 20'h22222, 8'h3C, 8'h00, 8'h00, rand_tags(),
                2, 0, 0, 1'b0, 1'b0);

        // response stalled while a new request waits
        pol_start = 0;
        run_txn(6'd40, 20'h77777, 8'h0F, 8'h00, 8'h00, rand_tags(),
                0, 0, 5, 1'b1, 1'b0);
        run_txn(6'd41, 20'h88888, 8'h00, 8'h00, 8'h00, rand_tags(),
                0, 0, 0, 1'b0, 1'b0);

        // reset while the writeback is stalled
        pol_start = 3;
        run_txn(6'd12, 20'h99999, 8'hFF, 8'hFF, 8'h00, rand_tags(),
                0, 50, 0, 1'b0, 1'b1);
        bus.wb_ready_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("mid_rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("mid_rst_alloc", 64'(bus.alloc_o), 64'd0);
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        alloc_seen = 0;
        repeat (4) begin
            @(posedge clk); #2;
            if (bus.alloc_o || bus.updt_o || bus.wb_valid_o) alloc_seen++;
        end
        chk("mid_rst_quiet", 64'(alloc_seen), 64'd0);

        for (int i = 0; i < 200; i++) begin
            pol_start = $urandom % WAYS;
            df = WAYS'($urandom & $urandom & $urandom);
            if ($urandom % 8 == 0) df = '1;
            block = ($urandom % 4 == 0) ? $urandom_range(1, MR + 1) : 0;
            run_txn(SW'($urandom), TW'($urandom), WAYS'($urandom),
                    WAYS'($urandom), df, rand_tags(), block,
                    $urandom % 4, $urandom % 4, 1'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
